// File: rtl/pll_clk_seq.sv
`default_nettype none
// ============================================================================
// pll_clk_seq : lock-tracking reset sequencer and power-of-two clock divider
// Rev 1.0
// ============================================================================
module pll_clk_seq #(
  parameter int STAGES   = 5,
  parameter int HOLD_CYC = 15,
  parameter int CW       = 4,
  parameter int LOSS_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOCKED,
  input  logic [2:0]        DIV_SEL,
  output logic              RSTX_FAST,
  output logic              CLK_DIV,
  output logic [STAGES-1:0] TICK,
  output logic              RSTX_DIV,
  output logic [LOSS_W-1:0] LOSS_CNT
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RUN       = 2'd2,
    S_LOST      = 2'd3
  } state_t;

  localparam logic [CW-1:0]     C_HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [2:0]        C_SEL_MAX   = 3'(STAGES - 1);
  localparam logic [STAGES-1:0] C_ONE       = STAGES'(1);
  localparam logic [LOSS_W-1:0] C_LOSS_MAX  = {LOSS_W{1'b1}};

  state_t              r_state;
  logic                r_lock_m;
  logic                r_lock_s;
  logic [CW-1:0]       r_hold;
  logic [STAGES-1:0]   r_p;
  logic [2:0]          r_sel;
  logic [1:0]          r_edge;
  logic                r_rstx_fast;
  logic                r_clk_div;
  logic [STAGES-1:0]   r_tick;
  logic                r_rstx_div;
  logic [LOSS_W-1:0]   r_loss;

  logic [2:0]          w_sel_clamp;
  logic [2:0]          w_sel_run;
  logic [STAGES-1:0]   w_p_inc;
  logic                w_div_run;
  logic                w_rise;
  logic [1:0]          w_edge_run;
  logic [STAGES-1:0]   w_tick_run;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_lock_m <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_lock_m <= LOCKED;
      r_lock_s <= r_lock_m;
    end
  end

  // Next-cycle RUN outputs are derived from the incremented phase so every
  // output can be a plain flop; the tap only changes at a phase wrap.
  always_comb begin
    w_sel_clamp = (DIV_SEL > C_SEL_MAX) ? C_SEL_MAX : DIV_SEL;
    w_p_inc     = r_p + C_ONE;
    w_sel_run   = (&r_p) ? w_sel_clamp : r_sel;
    w_div_run   = |(w_p_inc & (C_ONE << w_sel_run));
    w_rise      = w_div_run & ~r_clk_div;
    w_edge_run  = (w_rise && (r_edge != 2'd3)) ? r_edge + 2'd1 : r_edge;
    w_tick_run  = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_tick_run[k] = ((w_p_inc & ((C_ONE << (k + 1)) - C_ONE)) == (C_ONE << k));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_WAIT_LOCK;
      r_hold      <= '0;
      r_p         <= '0;
      r_sel       <= '0;
      r_edge      <= '0;
      r_rstx_fast <= 1'b0;
      r_clk_div   <= 1'b0;
      r_tick      <= '0;
      r_rstx_div  <= 1'b0;
      r_loss      <= '0;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state <= S_HOLD;
            r_hold  <= '0;
          end
        end
        S_HOLD: begin
          if (!r_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_hold  <= '0;
          end else if (r_hold == C_HOLD_LAST) begin
            r_state     <= S_RUN;
            r_hold      <= '0;
            r_rstx_fast <= 1'b1;
            r_p         <= '0;
            r_sel       <= w_sel_clamp;
            r_edge      <= '0;
            r_clk_div   <= 1'b0;
            r_tick      <= '0;
          end else begin
            r_hold <= r_hold + CW'(1);
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            r_state     <= S_LOST;
            r_rstx_fast <= 1'b0;
            r_rstx_div  <= 1'b0;
            r_clk_div   <= 1'b0;
            r_tick      <= '0;
            r_p         <= '0;
            r_edge      <= '0;
            if (r_loss != C_LOSS_MAX) begin
              r_loss <= r_loss + LOSS_W'(1);
            end
          end else begin
            r_p       <= w_p_inc;
            r_sel     <= w_sel_run;
            r_clk_div <= w_div_run;
            r_tick    <= w_tick_run;
            r_edge    <= w_edge_run;
            if (w_edge_run == 2'd2) begin
              r_rstx_div <= 1'b1;
            end
          end
        end
        S_LOST: begin
          r_state <= S_WAIT_LOCK;
        end
        default: begin
          r_state <= S_WAIT_LOCK;
        end
      endcase
    end
  end

  assign RSTX_FAST = r_rstx_fast;
  assign CLK_DIV   = r_clk_div;
  assign TICK      = r_tick;
  assign RSTX_DIV  = r_rstx_div;
  assign LOSS_CNT  = r_loss;

endmodule
`default_nettype wire

// File: tb/tb_pll_clk_seq.sv
`default_nettype none
// ============================================================================
// tb_pll_clk_seq : directed scoreboard bench for pll_clk_seq (LOSS_W = 2)
// Rev 1.0
// ============================================================================
module tb_pll_clk_seq;

  localparam int STAGES = 5;
  localparam int LOSS_W = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic              LOCKED;
  logic [2:0]        DIV_SEL;
  logic              RSTX_FAST;
  logic              CLK_DIV;
  logic [STAGES-1:0] TICK;
  logic              RSTX_DIV;
  logic [LOSS_W-1:0] LOSS_CNT;

  pll_clk_seq #(
    .STAGES   (STAGES),
    .HOLD_CYC (15),
    .CW       (4),
    .LOSS_W   (LOSS_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LOCKED    (LOCKED),
    .DIV_SEL   (DIV_SEL),
    .RSTX_FAST (RSTX_FAST),
    .CLK_DIV   (CLK_DIV),
    .TICK      (TICK),
    .RSTX_DIV  (RSTX_DIV),
    .LOSS_CNT  (LOSS_CNT)
  );

  always #5 CLK = ~CLK;

  // Vector layout: {RSTX_FAST, CLK_DIV, TICK[4:0], RSTX_DIV, LOSS_CNT[1:0]}
  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [9:0] zero_vec(logic [1:0] lc);
    return {8'b0, lc};
  endfunction

  // i = cycles since RUN entry; p = i mod 32, tap from sel
  function automatic logic [9:0] run_vec(int i, int sel, int rd_at, logic [1:0] lc);
    int         p;
    logic       cd;
    logic [4:0] tk;
    p  = i % 32;
    cd = ((p >> sel) & 1) != 0;
    for (int k = 0; k < 5; k++) tk[k] = ((p % (2 << k)) == (1 << k));
    return {1'b1, cd, tk, (i >= rd_at), lc};
  endfunction

  task automatic push(string tag, logic [9:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic compare_head();
    exp_t       e;
    logic [9:0] obs;
    obs = {RSTX_FAST, CLK_DIV, TICK, RSTX_DIV, LOSS_CNT};
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %b required a queued entry", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic check_n(int n);
    repeat (n) begin
      @(negedge CLK);
      compare_head();
    end
  endtask

  task automatic relock(int sel, int n, logic [1:0] lc, string tag);
    LOCKED = 1'b1;
    for (int k = 0; k < 17; k++) push({tag, "_wait"}, zero_vec(lc));
    for (int i = 0; i < n; i++) push({tag, "_run"}, run_vec(i, sel, 3 << sel, lc));
    check_n(17 + n);
  endtask

  task automatic drop(int sel, int i0, logic [1:0] lc_b, logic [1:0] lc_a, string tag);
    LOCKED = 1'b0;
    push({tag, "_lag"}, run_vec(i0, sel, 3 << sel, lc_b));
    push({tag, "_lag"}, run_vec(i0 + 1, sel, 3 << sel, lc_b));
    for (int k = 0; k < 3; k++) push({tag, "_lost"}, zero_vec(lc_a));
    check_n(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST     = 1'b1;
    LOCKED  = 1'b1;
    DIV_SEL = 3'd2;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) push("reset_hold", zero_vec(2'd0));
    check_n(3);

    // Lock-up straight out of reset with sel = 2
    RST = 1'b0;
    for (int k = 0; k < 17; k++) push("lockup_wait", zero_vec(2'd0));
    for (int i = 0; i < 70; i++) push("lockup_sel2", run_vec(i, 2, 12, 2'd0));
    check_n(87);

    // 2 -> 0 mid-lap: takes effect only at the wrap (i = 96)
    DIV_SEL = 3'd0;
    for (int i = 70; i < 106; i++) push("divsel_2to0", run_vec(i, (i < 96) ? 2 : 0, 12, 2'd0));
    check_n(36);

    // 7 clamps to 4 at the next wrap (i = 128)
    DIV_SEL = 3'd7;
    for (int i = 106; i < 180; i++) push("divsel_clamp", run_vec(i, (i < 128) ? 0 : 4, 12, 2'd0));
    check_n(74);

    // Loss at p = 20, then re-lock with p restarting at 0
    drop(4, 180, 2'd0, 2'd1, "loss1");
    relock(4, 60, 2'd1, "relock1");
    drop(4, 60, 2'd1, 2'd2, "loss2");

    // Glitch during HOLD restarts the whole sequence, no loss counted
    LOCKED = 1'b1;
    for (int k = 0; k < 26; k++) push("glitch_wait", zero_vec(2'd2));
    for (int i = 0; i < 10; i++) push("glitch_run", run_vec(i, 4, 48, 2'd2));
    check_n(6);
    LOCKED = 1'b0;
    check_n(3);
    LOCKED = 1'b1;
    check_n(27);
    drop(4, 10, 2'd2, 2'd3, "loss3");

    // Saturation of the 2-bit loss counter
    relock(4, 8, 2'd3, "relock4");
    drop(4, 8, 2'd3, 2'd3, "loss4_sat");
    relock(4, 8, 2'd3, "relock5");
    drop(4, 8, 2'd3, 2'd3, "loss5_sat");

    // Asynchronous reset mid-RUN, checked between clock edges
    relock(4, 20, 2'd3, "relock6");
    #2;
    RST = 1'b1;
    #1;
    push("async_rst", zero_vec(2'd0));
    compare_head();
    for (int k = 0; k < 2; k++) push("rst_held", zero_vec(2'd0));
    check_n(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_clk_seq.md
# pll_clk_seq

Parametrised reset sequencer and divided-clock generator for the PLL output domain. It is the successor to the fixed divide-by-32 / two-flop lock sequencer. It runs entirely on the PLL output clock and tracks the PLL lock indication. After lock it releases a fast-domain reset, then generates a selectable power-of-two divided clock with per-stage tick strobes and a reset aligned to that divided clock. Unlike the previous block, it detects lock loss mid-run, re-sequences automatically, and counts loss events.

## Interface
Parameters:
- STAGES, 5: number of divide-by-2 stages (1..8); tap k runs at CLK/2^(k+1).
- HOLD_CYC, 15: cycles spent in HOLD after lock before releasing reset (1..2^CW-1).
- CW, 4: width of the hold counter.
- LOSS_W, 8: width of the lock-loss event counter.

Ports:
- CLK  in  1  PLL output clock; the only clock.
- RST  in  1  asynchronous, active-high reset.
- LOCKED  in  1  PLL lock, asynchronous to CLK.
- DIV_SEL  in  3  divided-clock tap select; values ≥ STAGES clamp to STAGES-1.
- RSTX_FAST  out  1  active-low reset for the CLK domain.
- CLK_DIV  out  1  registered divided clock (tap selected by DIV_SEL).
- TICK  out  STAGES  TICK[k] is a one-cycle strobe on each rising edge of tap k.
- RSTX_DIV  out  1  active-low reset aligned to CLK_DIV.
- LOSS_CNT  out  LOSS_W  saturating count of lock losses seen in RUN.

## Operation
- LOCKED passes through a two-flop synchroniser to give lock_s; the synchroniser resets to 0.
- The FSM has four states: WAIT_LOCK, HOLD, RUN, LOST.
- Reset: state is WAIT_LOCK. All outputs are 0, the hold counter is 0, the phase counter is 0 and LOSS_CNT is 0.
- WAIT_LOCK: when lock_s = 1, go to HOLD with the hold counter at 0.
- HOLD: the hold counter increments every cycle.
  - lock_s = 0 → WAIT_LOCK. LOSS_CNT is unchanged.
  - hold counter = HOLD_CYC-1 → RUN.
- RUN:
  - RSTX_FAST = 1.
  - Phase counter p (STAGES bits) is 0 in the first RUN cycle and increments every cycle, wrapping modulo 2^STAGES.
  - lock_s = 0 → LOST.
- LOST: lasts exactly one cycle, then goes to WAIT_LOCK.
  - In the LOST cycle, RSTX_FAST, RSTX_DIV, CLK_DIV and TICK are 0, and p is cleared.
  - LOSS_CNT increments once on the RUN→LOST transition and saturates at 2^LOSS_W-1.
- Tap select: sel is latched from the clamped DIV_SEL on RUN entry and on every wrap (p = 2^STAGES-1 → 0). A change of DIV_SEL between those points has no effect, so CLK_DIV never produces runt pulses.
- In RUN, outputs are functions of the current p:
  - CLK_DIV = p[sel].
  - TICK[k] = 1 iff p[k] = 1 and p[k-1:0] = 0, i.e. p mod 2^(k+1) = 2^k.
- Outside RUN, CLK_DIV = 0 and TICK = 0.
- RSTX_DIV rises in the cycle of the second CLK_DIV rising edge after RUN entry, counted with a 2-bit saturating edge counter that is cleared outside RUN.
  - With sel = k, this is p = 3·2^k. The edge counter counts correctly across a wrap of p.
  - RSTX_DIV stays 1 until RST or LOST.
- RST asserted at any time forces all state and outputs to their reset values immediately (asynchronously), including mid-RUN. LOSS_CNT clears.

## Timing
- LOCKED sampled high at edge E → lock_s = 1 after E+1 → HOLD after E+2 → RUN after E+2+HOLD_CYC.
  - RSTX_FAST rises at that edge, i.e. E+17 for the defaults.
- LOCKED sampled low at edge E while in RUN → LOST after E+2. RSTX_FAST, RSTX_DIV and CLK_DIV fall at E+2; LOSS_CNT updates at E+2.
- A re-lock after LOST needs the full sequence again: WAIT_LOCK, then HOLD_CYC cycles of HOLD.
- A LOCKED low pulse shorter than 1 cycle may be missed. That is acceptable: the PLL guarantees a multi-cycle deassertion.
- CLK_DIV period is 2^(sel+1) cycles at 50 % duty. TICK[k] has a period of 2^(k+1) cycles.
- All outputs are driven directly from flops. No output has a combinational path from any input.

## Test plan
- Reset: assert RST with LOCKED = 1 → all outputs 0 and LOSS_CNT = 0 throughout. Deassert RST → RSTX_FAST = 1 at 17 cycles plus synchroniser alignment (defaults).
- Lock-up with DIV_SEL = 2: RSTX_FAST at E+17; CLK_DIV period 8, high for p = 4..7 mod 8; TICK[0] every 2 cycles, TICK[4] every 32; RSTX_DIV rises at p = 12.
- Glitch in HOLD: LOCKED low for 3 cycles at hold count 5 → FSM returns to WAIT_LOCK; RUN is reached 17 cycles after the final rise; LOSS_CNT = 0.
- Loss in RUN: LOCKED low at p = 20 → two cycles later RSTX_FAST, RSTX_DIV and CLK_DIV = 0 and LOSS_CNT = 1. Re-lock → RUN again with p starting at 0.
- DIV_SEL change: 2→0 at p = 5 → CLK_DIV keeps period 8 until p wraps to 0, then has period 2. DIV_SEL = 7 → behaves as 4 (period 32).
- Saturation and async reset: with LOSS_W = 2, run 5 lock-loss cycles → LOSS_CNT = 3. Then assert RST mid-RUN → all outputs 0 in the same cycle, without waiting for a CLK edge.
